// File: rtl/intv_rom_loader.sv
`default_nettype none
// ============================================================================
// Module   : intv_rom_loader
// Purpose  : Packs HPS cartridge download bytes into big-endian 16-bit words
//            and writes them through a small FIFO to cartridge memory.
// Revision : 1.0 - initial release
// ============================================================================
module intv_rom_loader #(
   parameter logic [7:0] ROM_INDEX  = 8'd1,
   parameter int         ADDR_W     = 16,
   parameter int         FIFO_DEPTH = 4
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              ioctl_download,
   input  logic [7:0]        ioctl_index,
   input  logic              ioctl_wr,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   output logic              ioctl_wait,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_data,
   output logic              mem_we,
   input  logic              mem_ack,
   output logic              load_done,
   output logic [ADDR_W:0]   word_count,
   output logic              odd_pad,
   output logic              overflow
);

   localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int c_ENT_W = ADDR_W + 16;
   localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(FIFO_DEPTH);
   localparam logic [c_CNT_W-1:0] c_HIGH = c_CNT_W'(FIFO_DEPTH - 1);
   localparam logic [c_CNT_W-1:0] c_TWO  = c_CNT_W'(FIFO_DEPTH - 2);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_active;
   logic                r_start_held;
   logic                w_active;
   logic                w_rise;
   logic                w_start;

   logic                r_pending;
   logic [7:0]          r_hi;
   logic [ADDR_W-1:0]   r_hi_addr;
   logic [c_ENT_W-1:0]  r_fifo [FIFO_DEPTH];
   logic [c_PTR_W-1:0]  r_wptr;
   logic [c_PTR_W-1:0]  r_rptr;
   logic [c_CNT_W-1:0]  r_count;
   logic [c_CNT_W-1:0]  w_count_nxt;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [15:0]         r_mem_data;
   logic [ADDR_W:0]     r_word_count;
   logic                r_odd_pad;
   logic                r_overflow;
   logic                r_wait;

   logic                w_stb;
   logic                w_flush_entry;
   logic [ADDR_W-1:0]   w_waddr;
   logic                w_full;
   logic                w_two_free;
   logic                w_push;
   logic                w_push_ok;
   logic [ADDR_W-1:0]   w_push_addr;
   logic [15:0]         w_push_data;
   logic                w_pend_nxt;
   logic                w_latch;
   logic                w_drop;
   logic                w_set_odd;
   logic                w_pop;
   logic [c_ENT_W-1:0]  w_head;
   logic                w_unused_addr;

   assign w_active      = ioctl_download && (ioctl_index == ROM_INDEX);
   assign w_rise        = w_active && !r_active;
   assign w_stb         = ioctl_wr && w_active && (r_state == S_LOAD);
   assign w_flush_entry = (r_state == S_LOAD) && !w_active;
   assign w_waddr       = ioctl_addr[ADDR_W:1];
   assign w_unused_addr = &{1'b0, ioctl_addr[24:ADDR_W+1]};
   assign w_full        = (r_count == c_FULL);
   assign w_two_free    = (r_count <= c_TWO);
   assign w_pop         = r_mem_we && mem_ack;
   assign w_push_ok     = w_push && !w_full;
   assign w_head        = r_fifo[r_rptr];

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_active     <= 1'b0;
         r_start_held <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_active <= w_active;
         // A restart requested while draining is remembered until IDLE.
         if (w_start)
            r_start_held <= 1'b0;
         else if (w_rise && (r_state == S_FLUSH || r_state == S_DONE))
            r_start_held <= 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_rise || r_start_held) begin
               w_state_nxt = S_LOAD;
               w_start     = 1'b1;
            end
         end
         S_LOAD: begin
            if (!w_active)
               w_state_nxt = S_FLUSH;
         end
         S_FLUSH: begin
            if (!r_pending && (r_count == '0) && !r_mem_we)
               w_state_nxt = S_DONE;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------- byte pairing
   always_comb begin
      w_push      = 1'b0;
      w_push_addr = r_hi_addr;
      w_push_data = {r_hi, 8'h00};
      w_pend_nxt  = r_pending;
      w_latch     = 1'b0;
      w_drop      = 1'b0;
      w_set_odd   = 1'b0;
      if (w_start) begin
         w_pend_nxt = 1'b0;
      end else if (w_stb) begin
         if (ioctl_addr[0]) begin
            w_push      = 1'b1;
            w_push_addr = w_waddr;
            w_push_data = {(r_pending ? r_hi : 8'h00), ioctl_dout};
            w_pend_nxt  = 1'b0;
         end else if (!r_pending) begin
            w_latch    = 1'b1;
            w_pend_nxt = 1'b1;
         end else begin
            // Orphaned high byte goes out padded; the new byte needs a spare slot.
            w_push = 1'b1;
            if (w_two_free) begin
               w_latch    = 1'b1;
               w_pend_nxt = 1'b1;
            end else begin
               w_drop     = 1'b1;
               w_pend_nxt = 1'b0;
            end
         end
      end else if (w_flush_entry && r_pending) begin
         w_push     = 1'b1;
         w_pend_nxt = 1'b0;
         w_set_odd  = 1'b1;
      end
   end

   always_comb begin
      w_count_nxt = r_count;
      if (w_start)
         w_count_nxt = '0;
      else if (w_push_ok && !w_pop)
         w_count_nxt = r_count + c_CNT_W'(1);
      else if (w_pop && !w_push_ok)
         w_count_nxt = r_count - c_CNT_W'(1);
   end

   always_ff @(posedge clk_sys) begin
      if (w_push_ok)
         r_fifo[r_wptr] <= {w_push_addr, w_push_data};
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_pending    <= 1'b0;
         r_hi         <= 8'h00;
         r_hi_addr    <= '0;
         r_wptr       <= '0;
         r_rptr       <= '0;
         r_count      <= '0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_data   <= 16'h0000;
         r_word_count <= '0;
         r_odd_pad    <= 1'b0;
         r_overflow   <= 1'b0;
         r_wait       <= 1'b0;
      end else begin
         r_pending <= w_pend_nxt;
         r_count   <= w_count_nxt;
         r_wait    <= (w_count_nxt >= c_HIGH) || (w_state_nxt == S_FLUSH);

         if (w_latch) begin
            r_hi      <= ioctl_dout;
            r_hi_addr <= w_waddr;
         end

         if (w_start) begin
            r_wptr <= '0;
            r_rptr <= '0;
         end else begin
            if (w_push_ok)
               r_wptr <= r_wptr + c_PTR_W'(1);
            if (w_pop)
               r_rptr <= r_rptr + c_PTR_W'(1);
         end

         // Head stays in the FIFO while presented; it leaves only on ack.
         if (w_pop) begin
            r_mem_we <= 1'b0;
         end else if (!r_mem_we && (r_count != '0) && !w_start) begin
            r_mem_we   <= 1'b1;
            r_mem_addr <= w_head[c_ENT_W-1:16];
            r_mem_data <= w_head[15:0];
         end

         if (w_start)
            r_word_count <= '0;
         else if (w_pop && (r_word_count != '1))
            r_word_count <= r_word_count + (ADDR_W + 1)'(1);

         if (w_start)
            r_odd_pad <= 1'b0;
         else if (w_set_odd)
            r_odd_pad <= 1'b1;

         if (w_start)
            r_overflow <= 1'b0;
         else if ((w_push && w_full) || w_drop)
            r_overflow <= 1'b1;
      end
   end

   assign ioctl_wait = r_wait;
   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_addr;
   assign mem_data   = r_mem_data;
   assign load_done  = (r_state == S_DONE);
   assign word_count = r_word_count;
   assign odd_pad    = r_odd_pad;
   assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: doc/intv_rom_loader.md
INTV_ROM_LOADER -- requirements
Module: intv_rom_loader

Interface
REQ-001 SHALL have parameter ROM_INDEX, default 8'd1: ioctl_index value that selects a cartridge download.
REQ-002 SHALL have parameter ADDR_W, default 16: width of the word address.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: word FIFO depth (power of two, at least 2).
REQ-004 Ports, in this order:
- clk_sys  in  1: system clock.
- reset_n  in  1: reset, asynchronous, active-low.
- ioctl_download  in  1: HPS download active.
- ioctl_index  in  8: download file index.
- ioctl_wr  in  1: byte strobe, one cycle.
- ioctl_addr  in  25: byte address.
- ioctl_dout  in  8: byte data.
- ioctl_wait  out  1: backpressure to HPS.
- mem_addr  out  ADDR_W: cartridge word address.
- mem_data  out  16: cartridge word.
- mem_we  out  1: write request.
- mem_ack  in  1: write accepted.
- load_done  out  1: one-cycle pulse when a load completes.
- word_count  out  ADDR_W+1: words written in the current or last load.
- odd_pad  out  1: sticky flag; the last load ended on a half word.
- overflow  out  1: sticky flag; a byte was dropped because the FIFO was full.

Function
REQ-005 A download SHALL be active only while ioctl_download=1 and ioctl_index==ROM_INDEX; strobes at any other time SHALL be ignored.
REQ-006 State machine SHALL have states IDLE, LOAD, FLUSH and DONE.
- IDLE->LOAD on an active-download rising edge (registered compare).
- LOAD->FLUSH when the active download falls.
- FLUSH->DONE when the half-word register, FIFO and memory port are all empty.
- DONE->IDLE after one cycle.
REQ-007 On IDLE->LOAD the block SHALL clear word_count, odd_pad, overflow, the FIFO and the half-word register.
REQ-008 Byte pairing SHALL be big-endian.
- Strobe with ioctl_addr[0]=0: latch byte as high byte and word address ioctl_addr[ADDR_W:1]; set the pending flag.
- Strobe with ioctl_addr[0]=1: form {high, byte} (high=8'h00 if not pending) at ioctl_addr[ADDR_W:1]; push to FIFO; clear pending.
REQ-009 An even-address strobe arriving while pending SHALL first push the old pending word as {high,8'h00}, then latch the new byte. Both actions happen in the same cycle if the FIFO has 2 free slots; otherwise the new byte is dropped.
REQ-010 The FIFO SHALL hold {addr,data} entries. A push arriving while the FIFO is full SHALL be dropped and SHALL set overflow.
REQ-011 ioctl_wait SHALL be registered and SHALL be 1 while the FIFO count is at least FIFO_DEPTH-1, or the state is FLUSH. It SHALL be 0 otherwise.
REQ-012 Memory handshake:
- mem_we, mem_addr and mem_data are registered and held stable while mem_we=1 and mem_ack=0.
- The FIFO head is popped on mem_we&mem_ack.
- The next word may present in the cycle after the ack (max throughput one word per 2 cycles).
- mem_ack while mem_we=0 is ignored.
REQ-013 word_count SHALL increment on each mem_we&mem_ack and SHALL saturate at all-ones.
REQ-014 On entering FLUSH with pending=1, the block SHALL push {high,8'h00} and set odd_pad.
REQ-015 load_done SHALL be 1 only in DONE, for exactly one cycle.
REQ-016 A new active-download rising edge seen in FLUSH or DONE SHALL be held, and acted on when the block returns to IDLE.
REQ-017 Latency: an odd-byte strobe at cycle N with an empty FIFO and idle memory port SHALL give mem_we=1 at cycle N+2.

Reset
REQ-018 While reset_n=0, all state SHALL clear immediately (asynchronously): state=IDLE, FIFO empty, pending=0, ioctl_wait=0, mem_we=0, mem_addr=0, mem_data=0, load_done=0, word_count=0, odd_pad=0, overflow=0.
REQ-019 A reset in the middle of a load SHALL abandon the load without a load_done pulse. A download still active after reset is released SHALL be treated as a new rising edge.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Index 1, bytes 12 34 56 78 at addresses 0..3, mem_ack tied 1 -> writes (0,1234), (1,5678); word_count=2; load_done pulses once; odd_pad=0.
- 3 bytes AA BB CC then download falls -> writes (0,AABB), (1,CC00); odd_pad=1; word_count=2.
- mem_ack held 0 while 10 bytes stream -> ioctl_wait=1 at FIFO count 3; no overflow when the source obeys wait; after ack is released all 5 words are written in order.
- Source ignores wait, FIFO full, another odd strobe -> that word is dropped; overflow=1; the remaining words are intact.
- Strobes with ioctl_index=2 -> no mem_we, no load_done, all counters unchanged.
- reset_n low mid-load with mem_we=1 -> mem_we=0 immediately, no load_done; download held high after release -> a fresh load starts with word_count=0.
